// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
//   Moves one FFT frame at a time from the read side of the audio FIFO into
//   the FFT core. It waits for a whole frame to be buffered, holds the FFT in
//   reset, pulses start, then streams FRAME_LEN samples with sop/eop framing
//   and ready backpressure. The sample is picked from a packed stereo word
//   (left, right or floor-average mono). It also counts completed frames and
//   flags FIFO underruns.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   enable                    allow a new frame to begin
//   chan_mode                 0/3 left, 1 right, 2 mono average (latched at start)
//   fifo_rdata/wnum/empty     FIFO read data {L,R}, word count, empty flag
//   fifo_rd_en                FIFO read strobe (data valid one cycle later)
//   fft_rst, fft_start        FFT reset level and one-cycle start pulse
//   st_data/valid/sop/eop     output stream, st_ready is the sink's accept
//   busy                      feeder is not idle
//   frame_cnt                 completed frames (wraps)
//   underrun                  sticky: a read was wanted while the FIFO was empty
module fft_frame_feeder #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 11,
  parameter int RST_CYCLES = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            chan_mode,
  input  logic [2*DATA_W-1:0]   fifo_rdata,
  input  logic [CNT_W-1:0]      fifo_wnum,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  fft_rst,
  output logic                  fft_start,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  output logic                  st_sop,
  output logic                  st_eop,
  input  logic                  st_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  underrun
);

  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam int TMAX  = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [IDX_W-1:0] FRAME_IDX = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WNUM_NEED = CNT_W'(FRAME_LEN);

  typedef enum logic [2:0] {S_IDLE, S_RST_FFT, S_START, S_STREAM, S_GAP} state_t;

  state_t              state_r, state_nxt_s;
  logic [TMR_W-1:0]    timer_r;
  logic [IDX_W-1:0]    reads_r, beat_idx_r;
  logic                in_flight_r;
  logic [1:0]          buf_cnt_r, occ_s;
  logic [DATA_W-1:0]   buf0_r, buf1_r, sample_s;
  logic [1:0]          chan_r;
  logic                pop_s, eop_accept_s, read_want_s, rd_s;

  // Select the outgoing sample from a packed {L,R} word; mono is floor((L+R)/2).
  function automatic logic [DATA_W-1:0] pick_sample(input logic [2*DATA_W-1:0] word,
                                                   input logic [1:0] mode);
    logic [DATA_W:0] sum;
    sum = {word[2*DATA_W-1], word[2*DATA_W-1:DATA_W]} + {word[DATA_W-1], word[DATA_W-1:0]};
    case (mode)
      2'd1:    pick_sample = word[DATA_W-1:0];
      2'd2:    pick_sample = sum[DATA_W:1];
      default: pick_sample = word[2*DATA_W-1:DATA_W];
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Dwell timer for RST_FFT and GAP; restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        timer_r <= {TMR_W{1'b0}};
    else if (state_nxt_s != state_r) timer_r <= {TMR_W{1'b0}};
    else                            timer_r <= timer_r + TMR_W'(1);
  end

  // Handshake and read-permission terms shared by the FSM and datapath.
  // The beat popped this cycle frees its slot, so a read may be issued
  // alongside it; that keeps the stream bubble-free with only two slots.
  always_comb begin
    pop_s        = (buf_cnt_r != 2'd0) && st_ready;
    eop_accept_s = pop_s && (beat_idx_r == LAST_IDX);
    occ_s        = {1'b0, in_flight_r} + buf_cnt_r;
    read_want_s  = (state_r == S_STREAM) && (reads_r != FRAME_IDX) &&
                   ((occ_s - {1'b0, pop_s}) < 2'd2);
    rd_s         = read_want_s && !fifo_empty;
    sample_s     = pick_sample(fifo_rdata, chan_r);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (enable && (fifo_wnum >= WNUM_NEED)) state_nxt_s = S_RST_FFT;
        else                                    state_nxt_s = S_IDLE;
      end
      S_RST_FFT: begin
        if (timer_r == RST_LAST) state_nxt_s = S_START;
        else                     state_nxt_s = S_RST_FFT;
      end
      S_START: state_nxt_s = S_STREAM;
      S_STREAM: begin
        if (eop_accept_s) state_nxt_s = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        else              state_nxt_s = S_STREAM;
      end
      S_GAP: begin
        if (timer_r == GAP_LAST) state_nxt_s = S_IDLE;
        else                     state_nxt_s = S_GAP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode; stream outputs come straight from the buffer head registers.
  always_comb begin
    fft_rst    = (state_r == S_RST_FFT);
    fft_start  = (state_r == S_START);
    busy       = (state_r != S_IDLE);
    fifo_rd_en = rd_s;
    st_valid   = (buf_cnt_r != 2'd0);
    st_data    = buf0_r;
    st_sop     = st_valid && (beat_idx_r == {IDX_W{1'b0}});
    st_eop     = st_valid && (beat_idx_r == LAST_IDX);
  end

  // Frame bookkeeping: channel latch, read/beat counters, frame count, underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_r <= 1'b0;
      chan_r      <= 2'd0;
      reads_r     <= {IDX_W{1'b0}};
      beat_idx_r  <= {IDX_W{1'b0}};
      frame_cnt   <= 16'd0;
      underrun    <= 1'b0;
    end else begin
      in_flight_r <= rd_s;
      if (state_r == S_START) begin
        chan_r     <= chan_mode;
        reads_r    <= {IDX_W{1'b0}};
        beat_idx_r <= {IDX_W{1'b0}};
      end else begin
        if (rd_s)  reads_r    <= reads_r + IDX_W'(1);
        if (pop_s) beat_idx_r <= eop_accept_s ? {IDX_W{1'b0}} : beat_idx_r + IDX_W'(1);
      end
      if (eop_accept_s)              frame_cnt <= frame_cnt + 16'd1;
      if (read_want_s && fifo_empty) underrun  <= 1'b1;
    end
  end

  // Two-entry output buffer; buf0_r is always the head beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt_r <= 2'd0;
      buf0_r    <= {DATA_W{1'b0}};
      buf1_r    <= {DATA_W{1'b0}};
    end else begin
      case ({in_flight_r, pop_s})
        2'b10: begin
          if (buf_cnt_r == 2'd0) buf0_r <= sample_s;
          else                   buf1_r <= sample_s;
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b01: begin
          buf0_r    <= buf1_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_r == 2'd1) begin
            buf0_r <= sample_s;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= sample_s;
          end
        end
        default: buf_cnt_r <= buf_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
`timescale 1ns/1ps
module tb_fft_frame_feeder;
  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: FRAME_LEN=8, RST_CYCLES=4, GAP_CYCLES=0
  logic        rst = 1'b1, enable = 1'b0, st_ready = 1'b1;
  logic [1:0]  chan_mode = 2'd0;
  logic [31:0] fifo_rdata = 32'd0;
  logic [CW-1:0] fifo_wnum;
  logic        fifo_empty, fifo_rd_en, fft_rst, fft_start, st_valid, st_sop, st_eop, busy, underrun;
  logic [15:0] st_data, frame_cnt;

  // second DUT: GAP_CYCLES=3, fed from an always-full source
  logic        g_rst = 1'b1, g_enable = 1'b1, g_ready = 1'b1, g_empty = 1'b0;
  logic [1:0]  g_mode = 2'd0;
  logic [31:0] g_rdata = 32'd0;
  logic [CW-1:0] g_wnum = 11'd8;
  logic        g_rd_en, g_fft_rst, g_fft_start, g_valid, g_sop, g_eop, g_busy, g_underrun;
  logic [15:0] g_data, g_frame_cnt, g_rcnt = 16'd0;

  fft_frame_feeder #(.DATA_W(16), .FRAME_LEN(8), .CNT_W(CW), .RST_CYCLES(4), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .chan_mode(chan_mode), .fifo_rdata(fifo_rdata),
    .fifo_wnum(fifo_wnum), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fft_rst(fft_rst),
    .fft_start(fft_start), .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .busy(busy), .frame_cnt(frame_cnt), .underrun(underrun));

  fft_frame_feeder #(.DATA_W(16), .FRAME_LEN(8), .CNT_W(CW), .RST_CYCLES(4), .GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst(g_rst), .enable(g_enable), .chan_mode(g_mode), .fifo_rdata(g_rdata),
    .fifo_wnum(g_wnum), .fifo_empty(g_empty), .fifo_rd_en(g_rd_en), .fft_rst(g_fft_rst),
    .fft_start(g_fft_start), .st_data(g_data), .st_valid(g_valid), .st_sop(g_sop), .st_eop(g_eop),
    .st_ready(g_ready), .busy(g_busy), .frame_cnt(g_frame_cnt), .underrun(g_underrun));

  // ---------------- FIFO model for the main DUT ----------------
  logic [31:0] mem [0:255];
  int wr_ptr = 0, rd_ptr = 0;
  logic force_empty = 1'b0;
  assign fifo_wnum  = CW'(wr_ptr - rd_ptr);
  assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;

  always @(posedge clk) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (g_rst) g_rcnt <= 16'd0;
    else if (g_rd_en) begin
      g_rdata <= {g_rcnt, ~g_rcnt};
      g_rcnt  <= g_rcnt + 16'd1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [15:0] d; logic sop; logic eop; } beat_t;
  beat_t exp_q[$];
  int vectors = 0, miscompares = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic [15:0] e, input int idx);
    beat_t b;
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    b.d = e; b.sop = (idx == 0); b.eop = (idx == 7);
    exp_q.push_back(b);
  endtask

  task automatic check_outputs_zero(input string name);
    logic [39:0] v;
    v = {fifo_rd_en, fft_rst, fft_start, st_data, st_valid, st_sop, st_eop, busy, frame_cnt, underrun};
    check(v == 40'd0, name, v, 0);
  endtask

  // ---------------- monitor for the main DUT ----------------
  int cyc = 0, rd_cnt = 0, acc_cnt = 0, rst_run = 0;
  int rd_first, rd_last, beat_first, beat_last;
  int last_rd_cnt = 0, last_rd_span = 0, last_beat_span = 0, last_lat = 0;
  bit prev_rst = 0, prev_start = 0, prev_stall = 0, accept;
  logic [18:0] prev_out;
  beat_t e;

  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_cnt = 0; acc_cnt = 0; rst_run = 0;
        prev_rst = 0; prev_start = 0; prev_stall = 0;
      end else begin
        accept = st_valid && st_ready;
        if (fft_start) check(prev_rst && (rst_run == 4), "rst_len", rst_run, 4);
        if (prev_start) check(!fft_start, "start_width", fft_start, 0);
        rst_run = fft_rst ? rst_run + 1 : 0;
        if (fifo_rd_en) begin
          if (rd_cnt == 0) rd_first = cyc;
          rd_last = cyc;
          rd_cnt++;
        end
        if (busy) check((rd_cnt - acc_cnt - int'(accept)) <= 2, "in_flight", rd_cnt - acc_cnt, 2);
        if (prev_stall)
          check({st_valid, st_sop, st_eop, st_data} == prev_out, "stall_hold",
                {st_valid, st_sop, st_eop, st_data}, prev_out);
        if (accept) begin
          if (exp_q.size() == 0) check(1'b0, "unexpected_beat", st_data, 0);
          else begin
            e = exp_q.pop_front();
            check({st_data, st_sop, st_eop} == {e.d, e.sop, e.eop}, "beat",
                  {st_data, st_sop, st_eop}, {e.d, e.sop, e.eop});
          end
          if (acc_cnt == 0) beat_first = cyc;
          beat_last = cyc;
          acc_cnt++;
          if (st_eop) begin
            last_rd_cnt = rd_cnt; last_rd_span = rd_last - rd_first;
            last_beat_span = beat_last - beat_first; last_lat = beat_first - rd_first;
            rd_cnt = 0; acc_cnt = 0;
          end
        end
        prev_stall = st_valid && !st_ready;
        prev_out   = {st_valid, st_sop, st_eop, st_data};
        prev_rst   = fft_rst;
        prev_start = fft_start;
      end
    end
  end

  // ---------------- monitor for the GAP_CYCLES=3 DUT ----------------
  int gcyc = 0, g_eop_cyc = 0, g_gaps = 0;
  bit g_eop_seen = 0, g_prev_rst = 0;
  logic [15:0] g_exp = 16'd0;

  initial begin : gmon
    forever begin
      @(negedge clk);
      gcyc++;
      if (!g_rst) begin
        if (g_valid && g_ready) begin
          check(g_data == g_exp, "gap_dut_data", g_data, g_exp);
          g_exp = g_exp + 16'd1;
          if (g_eop) begin g_eop_cyc = gcyc; g_eop_seen = 1; end
        end
        if (g_fft_rst && !g_prev_rst && g_eop_seen) begin
          check((gcyc - g_eop_cyc) >= 4, "gap_len", gcyc - g_eop_cyc, 4);
          g_gaps++;
        end
        g_prev_rst = g_fft_rst;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit toggle_ready = 0;
  initial begin : rdy_drv
    forever begin
      @(posedge clk); #1;
      if (toggle_ready) st_ready = ~st_ready;
    end
  end

  task automatic wait_frames(input int target);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      if (frame_cnt == 16'(target)) done = 1;
    end
    check(frame_cnt == 16'(target), "frame_cnt", frame_cnt, target);
  endtask

  task automatic wait_beats(input int n);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      if (acc_cnt >= n) done = 1;
    end
    check(acc_cnt >= n, "beat_wait", acc_cnt, n);
  endtask

  logic [31:0] mix_words [8] = '{32'h7FFF_0001, 32'h8000_FFFF, 32'hFFFF_0000, 32'h0002_0004,
                                 32'h0003_0000, 32'hFFFD_0000, 32'h1234_1234, 32'h8000_8000};
  logic [15:0] mono_exp  [8] = '{16'h4000, 16'hBFFF, 16'hFFFF, 16'h0003,
                                 16'h0001, 16'hFFFE, 16'h1234, 16'h8000};
  logic [15:0] right_exp [8] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0004,
                                 16'h0000, 16'h0000, 16'h1234, 16'h8000};

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b0; g_rst = 1'b0;

    // 1: basic left-channel frame
    enable = 1'b1; chan_mode = 2'd0;
    for (int i = 0; i < 8; i++) push_word({16'(i), 16'(16'h0100 + i)}, 16'(i), i);
    wait_frames(1);
    check(last_rd_cnt == 8, "rd_count", last_rd_cnt, 8);
    check(last_rd_span == 7, "rd_contig", last_rd_span, 7);
    check(last_beat_span == 7, "beat_contig", last_beat_span, 7);
    check(last_lat == 2, "first_beat_lat", last_lat, 2);

    // 2: mono average, then right channel
    chan_mode = 2'd2;
    for (int i = 0; i < 8; i++) push_word(mix_words[i], mono_exp[i], i);
    wait_frames(2);
    chan_mode = 2'd1;
    for (int i = 0; i < 8; i++) push_word(mix_words[i], right_exp[i], i);
    wait_frames(3);

    // 3: backpressure with alternating ready
    chan_mode = 2'd0;
    toggle_ready = 1;
    for (int i = 0; i < 8; i++) push_word({16'(16'h0A00 + i), 16'h0000}, 16'(16'h0A00 + i), i);
    wait_frames(4);
    #1; toggle_ready = 0; st_ready = 1'b1;

    // 4: one word short of a frame keeps the feeder idle
    for (int i = 0; i < 7; i++) push_word({16'(16'h0B00 + i), 16'h0000}, 16'(16'h0B00 + i), i);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check(!busy && !fft_rst, "idle_short", {busy, fft_rst}, 0);
    end
    push_word({16'h0B07, 16'h0000}, 16'h0B07, 7);
    @(negedge clk); check(fft_rst == 1'b0, "rst_not_early", fft_rst, 0);
    @(negedge clk); check(fft_rst == 1'b1, "rst_rise", fft_rst, 1);
    wait_frames(5);

    // 5: enable dropped mid-frame; 16 words buffered
    for (int i = 0; i < 16; i++) push_word({16'(16'h0C00 + i), 16'h0000}, 16'(16'h0C00 + i), i % 8);
    wait_beats(4);
    enable = 1'b0;
    wait_frames(6);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check(!busy, "idle_disabled", busy, 0);
    end

    // 6: FIFO starved mid-frame
    check(underrun == 1'b0, "underrun_clear", underrun, 0);
    enable = 1'b1;
    wait_beats(3);
    force_empty = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check(!fifo_rd_en, "rd_while_empty", fifo_rd_en, 0);
    end
    @(posedge clk); #1;
    force_empty = 1'b0;
    check(underrun == 1'b1, "underrun_set", underrun, 1);
    wait_frames(7);
    check(underrun == 1'b1, "underrun_sticky", underrun, 1);

    // 7: reset in the middle of a frame
    for (int i = 0; i < 8; i++) push_word({16'(16'h0D00 + i), 16'h0000}, 16'(16'h0D00 + i), i);
    wait_beats(2);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int i = 0; i < 8; i++) push_word({16'(16'h0E00 + i), 16'h0000}, 16'(16'h0E00 + i), i);
    wait_frames(1);

    repeat (5) @(posedge clk);
    check(exp_q.size() == 0, "sb_drained", exp_q.size(), 0);
    check(g_gaps >= 2, "gap_frames_seen", g_gaps, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
